// File: rtl/ai_cache_refill_ctrl_if.sv
// Handshake bundle between the refill controller, its requester, ai_cache and backing memory.
// master = controller side, slave = the surrounding environment.
interface ai_cache_refill_ctrl_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 128
);
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  rsp_err;
    logic                  cache_read_en;
    logic                  cache_write_en;
    logic [ADDR_WIDTH-1:0] cache_addr;
    logic [DATA_WIDTH-1:0] cache_write_data;
    logic [DATA_WIDTH-1:0] cache_read_data;
    logic                  cache_hit;
    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic [ADDR_WIDTH-1:0] mem_req_addr;
    logic                  mem_rsp_valid;
    logic [DATA_WIDTH-1:0] mem_rsp_data;

    modport master (
        input  req_valid, req_addr, rsp_ready, cache_read_data, cache_hit,
               mem_req_ready, mem_rsp_valid, mem_rsp_data,
        output req_ready, rsp_valid, rsp_data, rsp_err, cache_read_en, cache_write_en,
               cache_addr, cache_write_data, mem_req_valid, mem_req_addr
    );

    modport slave (
        output req_valid, req_addr, rsp_ready, cache_read_data, cache_hit,
               mem_req_ready, mem_rsp_valid, mem_rsp_data,
        input  req_ready, rsp_valid, rsp_data, rsp_err, cache_read_en, cache_write_en,
               cache_addr, cache_write_data, mem_req_valid, mem_req_addr
    );
endinterface

// File: rtl/ai_cache_refill_ctrl.sv
// Blocking refill controller: IDLE -> LOOKUP -> CHECK -> (MEM_REQ -> MEM_WAIT -> FILL) -> RESP.
// Define PERF_CNT_EN to add saturating hit/miss/timeout counters.
module ai_cache_refill_ctrl #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 128,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic clk,
    input  logic reset,
`ifdef PERF_CNT_EN
    output logic [31:0] hit_count,
    output logic [31:0] miss_count,
    output logic [31:0] timeout_count,
`endif
    ai_cache_refill_ctrl_if.master bus
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TC_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, LOOKUP, CHECK, MEM_REQ, MEM_WAIT, FILL, RESP} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] line_q, line_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  req_ready_q, req_ready_d;
    logic                  rd_en_q, rd_en_d;
    logic                  wr_en_q, wr_en_d;
    logic                  mem_vld_q, mem_vld_d;
    logic                  rsp_vld_q, rsp_vld_d;
    logic [ADDR_WIDTH-1:0] cache_addr_q, cache_addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        line_d     = line_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        cnt_d      = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    addr_d  = bus.req_addr;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: state_d = CHECK;
            CHECK: begin
                if (bus.cache_hit) begin
                    rsp_data_d = bus.cache_read_data;
                    rsp_err_d  = 1'b0;
                    state_d    = RESP;
                end else begin
                    state_d = MEM_REQ;
                end
            end
            MEM_REQ: begin
                if (bus.mem_req_ready) begin
                    cnt_d   = '0;
                    state_d = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                // A response arriving in the final wait cycle still beats the timeout.
                if (bus.mem_rsp_valid) begin
                    line_d  = bus.mem_rsp_data;
                    state_d = FILL;
                end else if (cnt_q == TC_LAST) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    state_d    = RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            FILL: begin
                rsp_data_d = line_q;
                rsp_err_d  = 1'b0;
                state_d    = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Strobes and buses are decoded from the next state so every output is a flop.
        req_ready_d  = (state_d == IDLE);
        rd_en_d      = (state_d == LOOKUP);
        wr_en_d      = (state_d == FILL);
        mem_vld_d    = (state_d == MEM_REQ);
        rsp_vld_d    = (state_d == RESP);
        cache_addr_d = (rd_en_d || wr_en_d) ? addr_d : '0;
        wdata_d      = wr_en_d ? line_d : '0;
        mem_addr_d   = mem_vld_d ? addr_d : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            line_q       <= '0;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b0;
            cnt_q        <= '0;
            req_ready_q  <= 1'b1;
            rd_en_q      <= 1'b0;
            wr_en_q      <= 1'b0;
            mem_vld_q    <= 1'b0;
            rsp_vld_q    <= 1'b0;
            cache_addr_q <= '0;
            wdata_q      <= '0;
            mem_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            line_q       <= line_d;
            rsp_data_q   <= rsp_data_d;
            rsp_err_q    <= rsp_err_d;
            cnt_q        <= cnt_d;
            req_ready_q  <= req_ready_d;
            rd_en_q      <= rd_en_d;
            wr_en_q      <= wr_en_d;
            mem_vld_q    <= mem_vld_d;
            rsp_vld_q    <= rsp_vld_d;
            cache_addr_q <= cache_addr_d;
            wdata_q      <= wdata_d;
            mem_addr_q   <= mem_addr_d;
        end
    end

    assign bus.req_ready        = req_ready_q;
    assign bus.rsp_valid        = rsp_vld_q;
    assign bus.rsp_data         = rsp_data_q;
    assign bus.rsp_err          = rsp_err_q;
    assign bus.cache_read_en    = rd_en_q;
    assign bus.cache_write_en   = wr_en_q;
    assign bus.cache_addr       = cache_addr_q;
    assign bus.cache_write_data = wdata_q;
    assign bus.mem_req_valid    = mem_vld_q;
    assign bus.mem_req_addr     = mem_addr_q;

`ifdef PERF_CNT_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;
    logic [31:0] to_cnt_q, to_cnt_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        to_cnt_d   = to_cnt_q;
        if (state_q == CHECK && bus.cache_hit && hit_cnt_q != '1)
            hit_cnt_d = hit_cnt_q + 32'd1;
        if (state_q == CHECK && !bus.cache_hit && miss_cnt_q != '1)
            miss_cnt_d = miss_cnt_q + 32'd1;
        if (state_q == MEM_WAIT && !bus.mem_rsp_valid && cnt_q == TC_LAST && to_cnt_q != '1)
            to_cnt_d = to_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            to_cnt_q   <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            to_cnt_q   <= to_cnt_d;
        end
    end

    assign hit_count     = hit_cnt_q;
    assign miss_count    = miss_cnt_q;
    assign timeout_count = to_cnt_q;
`endif
endmodule

// File: tb/tb_ai_cache_refill_ctrl.sv
// Randomized bench for ai_cache_refill_ctrl: behavioural ai_cache and memory around the DUT,
// expectations from a line-level reference model (which addresses are cached, what data comes back).
module tb_ai_cache_refill_ctrl;
    localparam int AW = 32;
    localparam int DW = 128;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    ai_cache_refill_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

`ifdef PERF_CNT_EN
    logic [31:0] hit_count, miss_count, timeout_count;
`endif

    ai_cache_refill_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk   (clk),
        .reset (rst),
`ifdef PERF_CNT_EN
        .hit_count     (hit_count),
        .miss_count    (miss_count),
        .timeout_count (timeout_count),
`endif
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    // Environment ai_cache: one-cycle read latency, written only by the DUT.
    logic [DW-1:0] env_cache [logic [AW-1:0]];
    always @(posedge clk) begin
        if (bus.cache_read_en) begin
            bus.cache_hit       <= env_cache.exists(bus.cache_addr);
            bus.cache_read_data <= env_cache.exists(bus.cache_addr) ? env_cache[bus.cache_addr] : '0;
        end
        if (bus.cache_write_en)
            env_cache[bus.cache_addr] = bus.cache_write_data;
    end

    // Reference model state.
    logic [DW-1:0] mem_img   [logic [AW-1:0]];
    logic [DW-1:0] ref_cache [logic [AW-1:0]];
    int ref_hits = 0, ref_misses = 0, ref_tos = 0;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic ensure_line(input logic [AW-1:0] a);
        if (!mem_img.exists(a))
            mem_img[a] = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic do_req(input logic [AW-1:0] addr, input int stall, input int lat,
                          input bit silent, input int hold);
        logic [DW-1:0] exp_data, held;
        bit exp_hit, exp_err, accepted, done;
        int n, req_cyc, hs_cyc, rsp_cyc, mem_hs, wr_cnt;
        ensure_line(addr);
        exp_hit = ref_cache.exists(addr);
        if (exp_hit) begin
            exp_data = ref_cache[addr]; exp_err = 0; ref_hits++;
        end else if (silent) begin
            exp_data = '0; exp_err = 1; ref_misses++; ref_tos++;
        end else begin
            exp_data = mem_img[addr]; exp_err = 0; ref_misses++;
            ref_cache[addr] = exp_data;
        end

        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        accepted = 0;
        for (int i = 0; i < 50 && !accepted; i++) begin
            if (bus.req_ready) accepted = 1;
            else @(negedge clk);
        end
        if (!accepted) begin
            chk("accept_timeout", 0, 1);
            bus.req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_addr  = $urandom;

        n = 0; done = 0; req_cyc = 0; hs_cyc = 0; rsp_cyc = 0; mem_hs = 0; wr_cnt = 0;
        while (!done && n < 300) begin
            @(negedge clk);
            n++;
            if (bus.cache_read_en && bus.cache_write_en) chk("rd_wr_overlap", 1, 0);
            if (bus.cache_write_en) begin
                wr_cnt++;
                chk("fill_data", bus.cache_write_data, exp_data);
                chk("fill_addr", bus.cache_addr, addr);
            end
            if (bus.mem_req_valid) begin
                chk("mem_req_addr", bus.mem_req_addr, addr);
                bus.mem_req_ready = (req_cyc >= stall);
                if (bus.mem_req_ready) begin
                    mem_hs++;
                    hs_cyc = n;
                end
                req_cyc++;
            end else begin
                bus.mem_req_ready = 1'b0;
            end
            if (!silent && hs_cyc > 0 && n == hs_cyc + lat) begin
                bus.mem_rsp_valid = 1'b1;
                bus.mem_rsp_data  = mem_img[addr];
            end else begin
                bus.mem_rsp_valid = 1'b0;
                bus.mem_rsp_data  = {$urandom, $urandom, $urandom, $urandom};
            end
            if (bus.rsp_valid) begin
                rsp_cyc = n;
                chk("rsp_data", bus.rsp_data, exp_data);
                chk("rsp_err", bus.rsp_err, exp_err);
                chk("req_ready_in_rsp", bus.req_ready, 0);
                held = bus.rsp_data;
                for (int h = 0; h < hold; h++) begin
                    bus.req_valid = 1'b1;
                    bus.req_addr  = $urandom;
                    @(negedge clk);
                    chk("hold_valid", bus.rsp_valid, 1);
                    chk("hold_data", bus.rsp_data, held);
                    chk("hold_req_ready", bus.req_ready, 0);
                end
                bus.req_valid = 1'b0;
                bus.rsp_ready = 1'b1;
                @(posedge clk);
                #1;
                bus.rsp_ready = 1'b0;
                done = 1;
            end
        end
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        if (!done) chk("rsp_never_came", 0, 1);
        chk("mem_req_count", mem_hs, exp_hit ? 0 : 1);
        chk("fill_count", wr_cnt, (exp_hit || silent) ? 0 : 1);
        if (exp_hit) chk("hit_latency", rsp_cyc, 3);
        if (silent && !exp_hit) chk("timeout_wait_cycles", rsp_cyc - hs_cyc - 1, TO);
        @(negedge clk);
        chk("back_to_idle", {bus.rsp_valid, bus.req_ready}, 2'b01);
    endtask

    // Memory data arriving while nothing is waiting for it must be dropped.
    task automatic late_noise();
        @(negedge clk);
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        bus.mem_rsp_valid = 1'b0;
        chk("late_rsp_no_fill", bus.cache_write_en, 0);
        chk("late_rsp_no_resp", bus.rsp_valid, 0);
        chk("late_rsp_idle", bus.req_ready, 1);
    endtask

    initial begin
        logic [AW-1:0] a;
        bit s;
        bus.req_valid = 0; bus.req_addr = '0; bus.rsp_ready = 0;
        bus.mem_req_ready = 0; bus.mem_rsp_valid = 0; bus.mem_rsp_data = '0;
        bus.cache_hit = 0; bus.cache_read_data = '0;
        mem_img[32'h40] = {16{8'hA5}};

        repeat (3) @(negedge clk);
        chk("rst_req_ready", bus.req_ready, 1);
        chk("rst_strobes", {bus.rsp_valid, bus.cache_read_en, bus.cache_write_en, bus.mem_req_valid}, 4'b0);
        chk("rst_rsp_data", bus.rsp_data, 0);
        rst = 1'b0;

        do_req(32'h40, 0, 5, 0, 0);
        do_req(32'h40, 0, 1, 0, 0);
        do_req(32'h80, 4, 2, 0, 0);
        do_req(32'hC0, 0, 1, 1, 0);
        late_noise();
        do_req(32'hC0, 0, 3, 0, 0);
        do_req(32'h100, 0, TO, 0, 0);
        do_req(32'h80, 0, 1, 0, 3);

        // Reset while waiting on memory: the aborted line must not land in the cache.
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_addr = 32'h200; bus.mem_req_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_mem_req", bus.mem_req_valid, 1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_req_ready", bus.req_ready, 1);
        chk("mid_rst_strobes", {bus.rsp_valid, bus.rsp_err, bus.cache_read_en,
                                bus.cache_write_en, bus.mem_req_valid}, 5'b0);
        chk("mid_rst_buses", bus.rsp_data | bus.cache_write_data | DW'(bus.cache_addr) | DW'(bus.mem_req_addr), 0);
`ifdef PERF_CNT_EN
        chk("mid_rst_counters", {hit_count, miss_count, timeout_count}, 0);
`endif
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = {$urandom, $urandom, $urandom, $urandom};
        ref_hits = 0; ref_misses = 0; ref_tos = 0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        bus.mem_rsp_valid = 1'b0;
        chk("post_rst_no_fill", bus.cache_write_en, 0);
        chk("post_rst_idle", bus.req_ready, 1);
        do_req(32'h200, 1, 2, 0, 1);

        for (int t = 0; t < 40; t++) begin
            a = 32'h40 * $urandom_range(1, 7);
            s = ($urandom_range(0, 5) == 0);
            do_req(a, $urandom_range(0, 4), $urandom_range(1, TO), s, $urandom_range(0, 3));
            if (s) late_noise();
        end

`ifdef PERF_CNT_EN
        chk("hit_count", hit_count, ref_hits);
        chk("miss_count", miss_count, ref_misses);
        chk("timeout_count", timeout_count, ref_tos);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
